// File: rtl/updown_pkg.sv
// updown_pkg: mode encodings and FSM state type shared by the up/down sequencer files.
package updown_pkg;
    typedef enum logic [1:0] {
        UP_WRAP   = 2'b00,
        DOWN_WRAP = 2'b01,
        PINGPONG  = 2'b10,
        ONESHOT   = 2'b11
    } mode_e;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        UP     = 2'b01,
        DOWN   = 2'b10,
        PAUSED = 2'b11
    } state_e;
endpackage

// File: rtl/updown_sequencer_if.sv
// updown_sequencer_if: control/status bundle of the sequencer; the turns counter
// exists only when TURN_CNT_EN is defined.
interface updown_sequencer_if #(parameter int N = 4);
    logic         start;
    logic         pause;
    logic         abort;
    logic [1:0]   mode;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic [N-1:0] count;
    logic         ud;
    logic         busy;
    logic         turn;
    logic         done;
    logic         err;
`ifdef TURN_CNT_EN
    logic [7:0]   turns;
    modport master(output start, pause, abort, mode, lo, hi,
                   input count, ud, busy, turn, done, err, turns);
    modport slave(input start, pause, abort, mode, lo, hi,
                  output count, ud, busy, turn, done, err, turns);
`else
    modport master(output start, pause, abort, mode, lo, hi,
                   input count, ud, busy, turn, done, err);
    modport slave(input start, pause, abort, mode, lo, hi,
                  output count, ud, busy, turn, done, err);
`endif
endinterface

// File: rtl/updown_cnt_core.sv
// updown_cnt_core: N-bit loadable up/down counter, modulo 2^N; load wins over enable.
module updown_cnt_core #(parameter int N = 4) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    input  logic         en_i,
    input  logic         ud_i,
    output logic [N-1:0] count_o
);
    logic [N-1:0] count_q, count_d;

    always_comb count_d = load_i ? load_val_i :
                          en_i   ? (ud_i ? count_q - N'(1) : count_q + N'(1)) : count_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else      count_q <= count_d;

    assign count_o = count_q;
endmodule

// File: rtl/updown_sequencer.sv
// updown_sequencer: bounded up/down/ping-pong/one-shot count sequencer with pause and abort.
// Defining TURN_CNT_EN adds a per-run saturating count of turn pulses.
module updown_sequencer #(parameter int N = 4) (
    input logic                clk,
    input logic                rst,
    updown_sequencer_if.slave  sq
);
    import updown_pkg::*;

    state_e       state_q, state_d;
    mode_e        mode_q, mode_d, mode_in;
    logic [N-1:0] lo_q, lo_d, hi_q, hi_d, ld_val, count;
    logic         ud_q, ud_d, turn_q, turn_d, done_q, done_d, err_q, err_d;
    logic         ld, en, dir, at_hi, at_lo;

    assign mode_in = mode_e'(sq.mode);
    assign at_hi   = count == hi_q;
    assign at_lo   = count == lo_q;

    updown_cnt_core #(.N(N)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ld),
        .load_val_i (ld_val),
        .en_i       (en),
        .ud_i       (dir),
        .count_o    (count)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ud_d    = ud_q;
        turn_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ld      = 1'b0;
        ld_val  = lo_q;
        en      = 1'b0;
        dir     = ud_q;
        case (state_q)
            IDLE: if (!sq.abort && sq.start) begin
                if (sq.lo <= sq.hi) begin
                    mode_d  = mode_in;
                    lo_d    = sq.lo;
                    hi_d    = sq.hi;
                    ld      = 1'b1;
                    ld_val  = mode_in == DOWN_WRAP ? sq.hi : sq.lo;
                    ud_d    = mode_in == DOWN_WRAP;
                    state_d = ud_d ? DOWN : UP;
                end else begin
                    err_d = 1'b1;
                end
            end
            // A paused run resumes by taking its next step on the release edge.
            default: if (sq.abort) begin
                state_d = IDLE;
            end else if (sq.pause) begin
                state_d = PAUSED;
            end else if (!ud_q) begin
                state_d = UP;
                if (!at_hi) begin
                    en = 1'b1;
                end else if (mode_q == PINGPONG || mode_q == ONESHOT) begin
                    state_d = DOWN;
                    ud_d    = 1'b1;
                    dir     = 1'b1;
                    en      = lo_q != hi_q;
                    turn_d  = 1'b1;
                end else begin
                    ld     = 1'b1;
                    ld_val = lo_q;
                    turn_d = 1'b1;
                end
            end else begin
                state_d = DOWN;
                if (!at_lo) begin
                    en = 1'b1;
                end else if (mode_q == ONESHOT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (mode_q == PINGPONG) begin
                    state_d = UP;
                    ud_d    = 1'b0;
                    dir     = 1'b0;
                    en      = lo_q != hi_q;
                    turn_d  = 1'b1;
                end else begin
                    ld     = 1'b1;
                    ld_val = hi_q;
                    turn_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= UP_WRAP;
            lo_q    <= '0;
            hi_q    <= '0;
            ud_q    <= 1'b0;
            turn_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ud_q    <= ud_d;
            turn_q  <= turn_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end

    assign sq.count = count;
    assign sq.ud    = ud_q;
    assign sq.busy  = state_q != IDLE;
    assign sq.turn  = turn_q;
    assign sq.done  = done_q;
    assign sq.err   = err_q;

`ifdef TURN_CNT_EN
    logic [7:0] turns_q, turns_d;

    always_comb turns_d = (state_q == IDLE && ld)      ? 8'd0 :
                          (turn_d && turns_q != 8'hFF) ? turns_q + 8'd1 : turns_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) turns_q <= 8'd0;
        else      turns_q <= turns_d;

    assign sq.turns = turns_q;
`endif
endmodule

// File: tb/tb_updown_sequencer.sv
// tb_updown_sequencer: table-driven directed vectors plus hand sequences for reset and turn counting.
module tb_updown_sequencer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    updown_sequencer_if #(.N(N)) sq();
    updown_sequencer #(.N(N)) dut (.clk(clk), .rst(rst), .sq(sq));

    typedef struct {
        logic s, p, a;
        logic [1:0] m;
        logic [N-1:0] lo, hi, c;
        logic ud, b, t, d, e;
    } vec_t;

    vec_t vq[$];
    int   vecs = 0;
    int   errs = 0;

    function automatic void v(logic s, p, a, logic [1:0] m, int lo, hi, c, logic ud, b, t, d, e);
        vq.push_back('{s, p, a, m, N'(lo), N'(hi), N'(c), ud, b, t, d, e});
    endfunction

    function automatic logic [N+4:0] outs();
        return {sq.count, sq.ud, sq.busy, sq.turn, sq.done, sq.err};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        {sq.start, sq.pause, sq.abort} = 3'b000;
        sq.mode = 2'd0;
        sq.lo   = '0;
        sq.hi   = '0;
        // UP_WRAP 2..5
        v(1,0,0,0,2,5, 2,0,1,0,0,0); v(0,0,0,0,2,5, 3,0,1,0,0,0);
        v(0,0,0,0,2,5, 4,0,1,0,0,0); v(0,0,0,0,2,5, 5,0,1,0,0,0);
        v(0,0,0,0,2,5, 2,0,1,1,0,0); v(0,0,0,0,2,5, 3,0,1,0,0,0);
        v(0,0,1,0,2,5, 3,0,0,0,0,0);
        // PINGPONG 0..3
        v(1,0,0,2,0,3, 0,0,1,0,0,0); v(0,0,0,2,0,3, 1,0,1,0,0,0);
        v(0,0,0,2,0,3, 2,0,1,0,0,0); v(0,0,0,2,0,3, 3,0,1,0,0,0);
        v(0,0,0,2,0,3, 2,1,1,1,0,0); v(0,0,0,2,0,3, 1,1,1,0,0,0);
        v(0,0,0,2,0,3, 0,1,1,0,0,0); v(0,0,0,2,0,3, 1,0,1,1,0,0);
        v(0,0,0,2,0,3, 2,0,1,0,0,0); v(0,0,1,2,0,3, 2,0,0,0,0,0);
        // ONESHOT 1..3
        v(1,0,0,3,1,3, 1,0,1,0,0,0); v(0,0,0,3,1,3, 2,0,1,0,0,0);
        v(0,0,0,3,1,3, 3,0,1,0,0,0); v(0,0,0,3,1,3, 2,1,1,1,0,0);
        v(0,0,0,3,1,3, 1,1,1,0,0,0); v(0,0,0,3,1,3, 1,1,0,0,1,0);
        v(0,0,0,3,1,3, 1,1,0,0,0,0);
        // bad bounds, then start while busy ignored
        v(1,0,0,0,6,4, 1,1,0,0,0,1); v(0,0,0,0,6,4, 1,1,0,0,0,0);
        v(1,0,0,0,0,3, 0,0,1,0,0,0); v(1,0,0,1,2,2, 1,0,1,0,0,0);
        v(0,0,0,1,2,2, 2,0,1,0,0,0); v(0,0,0,1,2,2, 3,0,1,0,0,0);
        v(0,0,0,1,2,2, 0,0,1,1,0,0); v(0,0,1,1,2,2, 0,0,0,0,0,0);
        // UP_WRAP 0..15 with pause at 7, abort (with pause) at 10
        v(1,0,0,0,0,15, 0,0,1,0,0,0);
        for (int i = 1; i <= 7; i++) v(0,0,0,0,0,15, i,0,1,0,0,0);
        for (int i = 0; i < 4; i++) v(0,1,0,0,0,15, 7,0,1,0,0,0);
        v(0,0,0,0,0,15, 8,0,1,0,0,0); v(0,0,0,0,0,15, 9,0,1,0,0,0);
        v(0,0,0,0,0,15, 10,0,1,0,0,0); v(0,1,1,0,0,15, 10,0,0,0,0,0);
        v(0,0,0,0,0,15, 10,0,0,0,0,0);
        // lo==hi ONESHOT and PINGPONG
        v(1,0,0,3,5,5, 5,0,1,0,0,0); v(0,0,0,3,5,5, 5,1,1,1,0,0);
        v(0,0,0,3,5,5, 5,1,0,0,1,0);
        v(1,0,0,2,5,5, 5,0,1,0,0,0); v(0,0,0,2,5,5, 5,1,1,1,0,0);
        v(0,0,0,2,5,5, 5,0,1,1,0,0); v(0,0,1,2,5,5, 5,0,0,0,0,0);
        // DOWN_WRAP 0..2
        v(1,0,0,1,0,2, 2,1,1,0,0,0); v(0,0,0,1,0,2, 1,1,1,0,0,0);
        v(0,0,0,1,0,2, 0,1,1,0,0,0); v(0,0,0,1,0,2, 2,1,1,1,0,0);
        v(0,0,1,1,0,2, 2,1,0,0,0,0);
        // UP_WRAP 14..15 at the top of the range; abort beats start in IDLE
        v(1,0,0,0,14,15, 14,0,1,0,0,0); v(0,0,0,0,14,15, 15,0,1,0,0,0);
        v(0,0,0,0,14,15, 14,0,1,1,0,0); v(0,0,0,0,14,15, 15,0,1,0,0,0);
        v(0,0,1,0,14,15, 15,0,0,0,0,0); v(1,0,1,0,0,3, 15,0,0,0,0,0);
        // UP_WRAP lo==hi: turn every cycle
        v(1,0,0,0,3,3, 3,0,1,0,0,0); v(0,0,0,0,3,3, 3,0,1,1,0,0);
        v(0,0,0,0,3,3, 3,0,1,1,0,0);

        #1 rst = 1'b0;
        #1 check("reset", 32'(outs()), 32'd0);
`ifdef TURN_CNT_EN
        check("reset_turns", 32'(sq.turns), 32'd0);
`endif
        @(negedge clk) rst = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            {sq.start, sq.pause, sq.abort} = {vq[i].s, vq[i].p, vq[i].a};
            sq.mode = vq[i].m;
            sq.lo   = vq[i].lo;
            sq.hi   = vq[i].hi;
            @(posedge clk) #1;
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({vq[i].c, vq[i].ud, vq[i].b, vq[i].t, vq[i].d, vq[i].e}));
        end
`ifdef TURN_CNT_EN
        check("turns_run", 32'(sq.turns), 32'd2);
`endif

        @(negedge clk) sq.abort = 1'b1;
        @(posedge clk) #1 check("abort_run", 32'(outs()), 32'({4'd3, 5'b00000}));
        @(negedge clk);
        sq.abort = 1'b0;
        sq.start = 1'b1;
        sq.mode  = 2'd2;
        sq.lo    = 4'd0;
        sq.hi    = 4'd3;
        @(posedge clk) #1 check("pp_start", 32'(outs()), 32'({4'd0, 5'b01000}));
        @(negedge clk) sq.start = 1'b0;
        @(posedge clk);
        @(posedge clk) #1 check("pp_at2", 32'(outs()), 32'({4'd2, 5'b01000}));
        #2 rst = 1'b0;
        #1 check("async_rst", 32'(outs()), 32'd0);
`ifdef TURN_CNT_EN
        check("async_rst_turns", 32'(sq.turns), 32'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk) #1;
            check($sformatf("post_rst%0d", i), 32'(outs()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
